// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between the async FIFO, the round-robin read arbiter and its consumers.
// The master modport is the arbiter's view; slave is the FIFO/consumer side.
interface fifo_rd_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) ();
  logic              r_empty;
  logic [DATA_W-1:0] r_data;
  logic              r_inc;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  out_ready;
  logic [DATA_W-1:0] out_data;
  logic [N_REQ-1:0]  out_valid;
  logic [N_REQ-1:0]  grant;
  logic              busy;

  modport master (
    input  r_empty, r_data, req, out_ready,
    output r_inc, out_data, out_valid, grant, busy
  );

  modport slave (
    output r_empty, r_data, req, out_ready,
    input  r_inc, out_data, out_valid, grant, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Shares the async FIFO read port among N_REQ consumers in round-robin bursts of up to
// MAX_BURST words, delivering popped words through a one-entry output register.
module fifo_rd_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               r_clk,
  input logic               r_rst,
  fifo_rd_arbiter_if.master bus
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [N_REQ-1:0]  out_valid_q, out_valid_d;

  logic            owner_req, accept, slot_free, pop;
  logic            sel_found;
  logic [PtrW-1:0] sel_idx, cand, gnt_idx, rr_next;

  assign owner_req = |(bus.req & grant_q);
  assign accept    = |(out_valid_q & bus.out_ready);
  assign slot_free = (out_valid_q == '0) || accept;
  assign pop       = (state_q == StBurst) && owner_req && !bus.r_empty && slot_free;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = PtrW'((int'(rr_ptr_q) + i) % int'(N_REQ));
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_q[i]) gnt_idx = PtrW'(i);
    end
    rr_next = PtrW'((int'(gnt_idx) + 1) % int'(N_REQ));
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (pop) begin
      out_data_d  = bus.r_data;
      out_valid_d = grant_q;
      beat_cnt_d  = beat_cnt_q + CntW'(1);
    end else if (accept) begin
      out_valid_d = '0;
    end

    case (state_q)
      StIdle: begin
        if (sel_found) begin
          grant_d    = N_REQ'(1) << sel_idx;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end else begin
          grant_d = '0;
        end
      end
      StBurst: begin
        if (!owner_req || (pop && beat_cnt_q == CntW'(MAX_BURST - 1))) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.r_inc     = pop;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == StBurst);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: a queue-backed FIFO model feeds the DUT and a scoreboard of
// {owner, word} entries is checked whenever a consumer accepts an output word.
module tb_fifo_rd_arbiter;

  logic r_clk;
  logic r_rst;

  fifo_rd_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  fifo_rd_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .bus   (bus)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0]  fifo_q[$];
  logic [11:0] sb_q[$];

  logic       s_inc, s_busy;
  logic [3:0] s_grant, s_valid;
  logic [7:0] s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    bus.r_empty = (fifo_q.size() == 0);
    bus.r_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] owner, input bit expect_out);
    fifo_q.push_back(d);
    if (expect_out) sb_q.push_back({owner, d});
    refresh();
  endtask

  // Sample outputs mid-cycle, score any accept, then advance the FIFO model past the edge.
  task automatic cycle();
    logic [11:0] e;
    @(negedge r_clk);
    s_inc   = bus.r_inc;
    s_busy  = bus.busy;
    s_grant = bus.grant;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    if (s_inc) check("pop_while_empty", 32'(bus.r_empty), 32'd0);
    if (|(s_valid & bus.out_ready)) begin
      if (sb_q.size() == 0) begin
        check("sb_occupancy", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", 32'(s_data), 32'(e[7:0]));
        check("sb_owner", 32'(s_valid), 32'(e[11:8]));
      end
    end
    @(posedge r_clk);
    #1;
    if (s_inc && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    r_rst         = 1'b1;
    bus.req       = '0;
    bus.out_ready = '0;
    fifo_q.delete();
    sb_q.delete();
    refresh();
    repeat (2) @(posedge r_clk);
    #1;
    r_rst = 1'b0;
  endtask

  logic [9:0] inc_exp, busy_exp;
  logic [7:0] grant4_exp;

  initial begin
    r_rst = 1'b1;
    do_reset();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_rinc", 32'(bus.r_inc), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single consumer: 4-word burst, bubble, 2-word burst, then stall on empty.
    bus.req = 4'b0001;
    bus.out_ready = 4'b0001;
    for (int k = 0; k < 6; k++) push(8'(8'h10 + k), 4'b0001, 1'b1);
    inc_exp  = 10'b0011011110;
    busy_exp = 10'b1111011110;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check($sformatf("t1_rinc_c%0d", i), 32'(s_inc), 32'(inc_exp[i]));
      check($sformatf("t1_busy_c%0d", i), 32'(s_busy), 32'(busy_exp[i]));
    end
    check("t1_drained", 32'(sb_q.size()), 32'd0);

    // Round-robin over four constant requesters, wrapping back to consumer 0.
    do_reset();
    bus.req = 4'b1111;
    bus.out_ready = 4'b1111;
    for (int k = 0; k < 16; k++) push(8'(8'h20 + k), 4'(1 << (k / 4)), 1'b1);
    for (int c = 0; c < 22; c++) begin
      cycle();
      check($sformatf("t2_grant_c%0d", c), 32'(s_grant),
            (c % 5 == 0) ? 32'd0 : 32'(1 << ((c / 5) % 4)));
      check($sformatf("t2_rinc_c%0d", c), 32'(s_inc),
            32'((c % 5 != 0) && (c < 20)));
    end
    check("t2_drained", 32'(sb_q.size()), 32'd0);

    // Back-pressure: owner stalls acceptance for three cycles after the first word.
    do_reset();
    bus.req = 4'b0001;
    for (int k = 0; k < 6; k++) push(8'(8'h30 + k), 4'b0001, (k < 4));
    inc_exp = 10'b0011100010;
    for (int i = 0; i < 9; i++) begin
      bus.out_ready = (i >= 2 && i <= 4) ? 4'b0000 : 4'b0001;
      cycle();
      check($sformatf("t3_rinc_c%0d", i), 32'(s_inc), 32'(inc_exp[i]));
      if (i >= 2 && i <= 4) begin
        check($sformatf("t3_hold_data_c%0d", i), 32'(s_data), 32'h30);
        check($sformatf("t3_hold_valid_c%0d", i), 32'(s_valid), 32'd1);
      end
    end
    check("t3_drained", 32'(sb_q.size()), 32'd0);

    // Owner drops its request after two beats; next grant goes to consumer 1.
    do_reset();
    bus.out_ready = 4'b1111;
    push(8'h40, 4'b0001, 1'b1);
    push(8'h41, 4'b0001, 1'b1);
    push(8'h42, 4'b0010, 1'b1);
    push(8'h43, 4'b0010, 1'b1);
    inc_exp = 10'b0001100110;
    grant4_exp = 8'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req = (i == 3) ? 4'b0010 : 4'b0011;
      cycle();
      check($sformatf("t4_rinc_c%0d", i), 32'(s_inc), 32'(inc_exp[i]));
      if (i >= 1 && i <= 3) check($sformatf("t4_grant_c%0d", i), 32'(s_grant), 32'd1);
      if (i == 4) check("t4_grant_idle", 32'(s_grant), 32'd0);
      if (i >= 5) check($sformatf("t4_grant_c%0d", i), 32'(s_grant), 32'd2);
    end
    check("t4_drained", 32'(sb_q.size()), 32'd0);

    // FIFO runs empty mid-burst; the burst holds until a second word shows up.
    do_reset();
    bus.req = 4'b0001;
    bus.out_ready = 4'b0001;
    push(8'h50, 4'b0001, 1'b1);
    inc_exp  = 10'b0001000010;
    busy_exp = 10'b0011111110;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) push(8'h51, 4'b0001, 1'b1);
      cycle();
      check($sformatf("t5_rinc_c%0d", i), 32'(s_inc), 32'(inc_exp[i]));
      check($sformatf("t5_busy_c%0d", i), 32'(s_busy), 32'(busy_exp[i]));
    end
    check("t5_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-burst with a held output word; round-robin pointer returns to 0.
    do_reset();
    bus.req = 4'b0001;
    bus.out_ready = 4'b0001;
    push(8'h60, 4'b0001, 1'b1);
    cycle();
    cycle();
    bus.req = 4'b0000;
    cycle();
    bus.req = 4'b0011;
    push(8'h61, 4'b0010, 1'b0);
    cycle();
    cycle();
    check("t6_grant_c1", 32'(s_grant), 32'd2);
    check("t6_rinc_c1", 32'(s_inc), 32'd1);
    cycle();
    check("t6_valid_held", 32'(s_valid), 32'd2);
    check("t6_data_held", 32'(s_data), 32'h61);
    r_rst = 1'b1;
    cycle();
    r_rst = 1'b0;
    cycle();
    check("t6_rst_grant", 32'(s_grant), 32'd0);
    check("t6_rst_busy", 32'(s_busy), 32'd0);
    check("t6_rst_valid", 32'(s_valid), 32'd0);
    check("t6_rst_data", 32'(s_data), 32'd0);
    check("t6_rst_rinc", 32'(s_inc), 32'd0);
    cycle();
    check("t6_rr_restart", 32'(s_grant), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
